// File: rtl/mem_router_pkg.sv
// Shared types and the address-decode helper for the memory region router.
// Tables are sized for the largest supported configuration (8 regions, 64-bit
// addresses); each instance pads its real region table into them.
package mem_router_pkg;

  localparam int MAX_REGIONS = 8;
  localparam int MAX_ADDR_W  = 64;
  localparam int ID_W        = $clog2(MAX_REGIONS + 1);

  typedef logic [ID_W-1:0] region_id_t;
  typedef logic [MAX_REGIONS-1:0][MAX_ADDR_W-1:0] region_tbl_t;

  // The miss ID is one past the last real region of the instance.
  function automatic region_id_t region_miss_id(input int n_regions);
    return region_id_t'(n_regions);
  endfunction

  // Lowest-index region whose masked address equals its base wins.
  function automatic region_id_t region_decode(input logic [MAX_ADDR_W-1:0] addr,
                                               input region_tbl_t           base,
                                               input region_tbl_t           mask,
                                               input int                    n_regions);
    region_id_t id;
    id = region_miss_id(n_regions);
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if ((i < n_regions) && ((addr & mask[i]) == base[i])) begin
        id = region_id_t'(i);
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/mem_router_id_fifo.sv
// Region-ID FIFO holding one entry per outstanding request, oldest at the head.
// Pointers wrap naturally (DEPTH is a power of two); the count carries one
// extra bit so full and empty are distinguishable.
module mem_router_id_fifo
  import mem_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  region_id_t             push_id_i,
  input  logic                   pop_i,
  output region_id_t             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  region_id_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_id_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_region_router.sv
// Routes host memory requests to one of N_REGIONS targets by address and
// returns responses strictly in issue order. Only one region may have requests
// in flight at a time, so ordering across targets is preserved by draining
// before a region switch. Decode misses get a local error response.
module mem_region_router
  import mem_router_pkg::*;
#(
  parameter int                          N_REGIONS   = 4,
  parameter int                          ADDR_W      = 32,
  parameter int                          DATA_W      = 32,
  parameter int                          MAX_OUTST   = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          h_req_i,
  output logic                          h_gnt_o,
  input  logic [ADDR_W-1:0]             h_addr_i,
  input  logic                          h_we_i,
  input  logic [DATA_W/8-1:0]           h_be_i,
  input  logic [DATA_W-1:0]             h_wdata_i,
  output logic                          h_rvalid_o,
  output logic [DATA_W-1:0]             h_rdata_o,
  output logic                          h_err_o,
  output logic [N_REGIONS-1:0]          t_req_o,
  input  logic [N_REGIONS-1:0]          t_gnt_i,
  output logic [ADDR_W-1:0]             t_addr_o,
  output logic                          t_we_o,
  output logic [DATA_W/8-1:0]           t_be_o,
  output logic [DATA_W-1:0]             t_wdata_o,
  input  logic [N_REGIONS-1:0]          t_rvalid_i,
  input  logic [N_REGIONS*DATA_W-1:0]   t_rdata_i,
  input  logic [N_REGIONS-1:0]          t_err_i,
  output logic                          proto_err_o,
  output logic [$clog2(MAX_OUTST):0]    outst_cnt_o
);

  localparam int         CNT_W   = $clog2(MAX_OUTST) + 1;
  localparam region_id_t ID_MISS = region_miss_id(N_REGIONS);

  region_tbl_t            base_tbl, mask_tbl;
  logic [MAX_ADDR_W-1:0]  addr_ext;
  region_id_t             sel;
  logic                   sel_gnt;
  logic                   issue_ok;

  region_id_t             head;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;
  logic [CNT_W-1:0]       cnt_after;

  region_id_t             last_id_q, last_id_d;
  logic                   miss_head_q, miss_head_d;
  logic                   proto_err_q, proto_err_d;

  logic                   rsp_vld, rsp_err;
  logic [DATA_W-1:0]      rsp_data;
  logic [N_REGIONS-1:0]   expect_mask;

  // Pad the per-instance region table into the package-sized table.
  always_comb begin
    base_tbl = '0;
    mask_tbl = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      base_tbl[i][ADDR_W-1:0] = REGION_BASE[i*ADDR_W +: ADDR_W];
      mask_tbl[i][ADDR_W-1:0] = REGION_MASK[i*ADDR_W +: ADDR_W];
    end
  end

  assign addr_ext = MAX_ADDR_W'(h_addr_i);
  assign sel      = region_decode(addr_ext, base_tbl, mask_tbl, N_REGIONS);

  // Issue is blocked when full or when the request targets a different
  // region than the ones still in flight.
  assign issue_ok = !fifo_full && (fifo_empty || (sel == last_id_q));

  // Grant comes from the selected target, or locally for a miss.
  always_comb begin
    sel_gnt = (sel == ID_MISS);
    for (int i = 0; i < N_REGIONS; i++) begin
      if (sel == region_id_t'(i)) sel_gnt = t_gnt_i[i];
    end
  end

  assign h_gnt_o = rst && h_req_i && issue_ok && sel_gnt;
  assign push    = h_gnt_o;

  // Route the request to the decoded target only.
  always_comb begin
    t_req_o = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      t_req_o[i] = rst && h_req_i && issue_ok && (sel == region_id_t'(i));
    end
  end

  assign t_addr_o  = rst ? h_addr_i  : '0;
  assign t_we_o    = rst && h_we_i;
  assign t_be_o    = rst ? h_be_i    : '0;
  assign t_wdata_o = rst ? h_wdata_i : '0;

  mem_router_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (push),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outst_cnt_o)
  );

  // Select the response of the head region; a miss at the head answers itself.
  always_comb begin
    rsp_vld     = 1'b0;
    rsp_err     = 1'b0;
    rsp_data    = '0;
    expect_mask = '0;
    if (miss_head_q) begin
      rsp_vld = 1'b1;
      rsp_err = 1'b1;
    end else if (!fifo_empty) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (head == region_id_t'(i)) begin
          expect_mask[i] = 1'b1;
          rsp_vld        = t_rvalid_i[i];
          rsp_err        = t_err_i[i];
          rsp_data       = t_rdata_i[i*DATA_W +: DATA_W];
        end
      end
    end
    if (!rsp_vld) rsp_err  = 1'b0;
    if (!rsp_vld || rsp_err) rsp_data = '0;
  end

  assign pop        = rsp_vld;
  assign h_rvalid_o = rsp_vld;
  assign h_err_o    = rsp_err;
  assign h_rdata_o  = rsp_data;

  // All in-flight entries share one region ID, so the head is a miss exactly
  // when the FIFO is non-empty and the last pushed ID is the miss ID.
  always_comb begin
    last_id_d   = push ? sel : last_id_q;
    cnt_after   = outst_cnt_o + CNT_W'(push) - CNT_W'(pop);
    miss_head_d = (cnt_after != '0) && (last_id_d == ID_MISS);
    proto_err_d = proto_err_q || (|(t_rvalid_i & ~expect_mask));
  end

  // Control state: last issued region, pending miss response, sticky protocol flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_id_q   <= '0;
      miss_head_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      last_id_q   <= last_id_d;
      miss_head_q <= miss_head_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router with four regions and four outstanding slots.
module tb_mem_region_router;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam logic [N*AW-1:0] BASES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N*AW-1:0] MASKS = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};

  logic              clk;
  logic              rst;
  logic              h_req, h_gnt, h_we, h_rvalid, h_err, proto_err;
  logic [AW-1:0]     h_addr, t_addr;
  logic [DW/8-1:0]   h_be, t_be;
  logic [DW-1:0]     h_wdata, h_rdata, t_wdata;
  logic [N-1:0]      t_req, t_gnt, t_rvalid, t_err;
  logic              t_we;
  logic [N*DW-1:0]   t_rdata;
  logic [$clog2(MO):0] outst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mem_region_router #(
    .N_REGIONS   (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_OUTST   (MO),
    .REGION_BASE (BASES),
    .REGION_MASK (MASKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h_req_i     (h_req),
    .h_gnt_o     (h_gnt),
    .h_addr_i    (h_addr),
    .h_we_i      (h_we),
    .h_be_i      (h_be),
    .h_wdata_i   (h_wdata),
    .h_rvalid_o  (h_rvalid),
    .h_rdata_o   (h_rdata),
    .h_err_o     (h_err),
    .t_req_o     (t_req),
    .t_gnt_i     (t_gnt),
    .t_addr_o    (t_addr),
    .t_we_o      (t_we),
    .t_be_o      (t_be),
    .t_wdata_o   (t_wdata),
    .t_rvalid_i  (t_rvalid),
    .t_rdata_i   (t_rdata),
    .t_err_i     (t_err),
    .proto_err_o (proto_err),
    .outst_cnt_o (outst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    h_req    = 1'b0;
    h_addr   = '0;
    h_we     = 1'b0;
    h_be     = '0;
    h_wdata  = '0;
    t_gnt    = '0;
    t_rvalid = '0;
    t_rdata  = '0;
    t_err    = '0;
  endtask

  task automatic read_req(input logic [AW-1:0] addr, input logic [N-1:0] gnt);
    h_req  = 1'b1;
    h_addr = addr;
    h_be   = 4'hF;
    t_gnt  = gnt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    // Reset state, with a request pending to show nothing leaks out.
    read_req(32'h0000_0010, 4'b0001);
    sample();
    sample();
    check("rst_gnt",     h_gnt, 0);
    check("rst_rvalid",  h_rvalid, 0);
    check("rst_treq",    t_req, 0);
    check("rst_taddr",   t_addr, 0);
    check("rst_cnt",     outst_cnt, 0);
    check("rst_proto",   proto_err, 0);
    next_cycle();
    rst = 1'b1;
    idle();

    // T1: region 0 read with response one cycle later.
    next_cycle();
    read_req(32'h0000_0010, 4'b0001);
    sample();
    check("t1_gnt",   h_gnt, 1);
    check("t1_treq",  t_req, 4'b0001);
    check("t1_taddr", t_addr, 32'h0000_0010);
    next_cycle();
    idle();
    t_rvalid = 4'b0001;
    t_rdata[31:0] = 32'hDEAD_BEEF;
    sample();
    check("t1_rvalid", h_rvalid, 1);
    check("t1_rdata",  h_rdata, 32'hDEAD_BEEF);
    check("t1_err",    h_err, 0);
    check("t1_cnt",    outst_cnt, 1);
    next_cycle();
    idle();
    sample();
    check("t1_drained", outst_cnt, 0);

    // T2: decode miss.
    next_cycle();
    read_req(32'h9000_0000, 4'b0000);
    sample();
    check("t2_gnt",  h_gnt, 1);
    check("t2_treq", t_req, 0);
    next_cycle();
    idle();
    sample();
    check("t2_rvalid", h_rvalid, 1);
    check("t2_err",    h_err, 1);
    check("t2_rdata",  h_rdata, 0);
    check("t2_treq2",  t_req, 0);
    next_cycle();
    sample();
    check("t2_rvalid_off", h_rvalid, 0);
    check("t2_cnt",        outst_cnt, 0);

    // T3: fill to MAX_OUTST with held-off responses.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      read_req(32'h1000_0000 + 32'(k * 4), 4'b0010);
      sample();
      check($sformatf("t3_gnt%0d", k), h_gnt, 1);
    end
    next_cycle();
    read_req(32'h1000_0010, 4'b0010);
    sample();
    check("t3_gnt_full",  h_gnt, 0);
    check("t3_treq_full", t_req, 0);
    check("t3_cnt_full",  outst_cnt, 4);
    next_cycle();
    t_rvalid = 4'b0010;
    t_rdata[63:32] = 32'h0000_0001;
    sample();
    check("t3_gnt_popcyc", h_gnt, 0);
    check("t3_rvalid",     h_rvalid, 1);
    next_cycle();
    t_rvalid = '0;
    sample();
    check("t3_gnt_after", h_gnt, 1);
    check("t3_cnt_after", outst_cnt, 3);
    next_cycle();
    idle();
    t_rvalid = 4'b0010;
    repeat (3) next_cycle();
    sample();
    check("t3_last_rvalid", h_rvalid, 1);
    next_cycle();
    idle();
    sample();
    check("t3_drained", outst_cnt, 0);

    // T4: region switch waits for drain.
    next_cycle();
    read_req(32'h0000_0020, 4'b0101);
    sample();
    check("t4_gnt_r0", h_gnt, 1);
    next_cycle();
    read_req(32'h2000_0000, 4'b0101);
    sample();
    check("t4_stall_treq", t_req, 0);
    check("t4_stall_gnt",  h_gnt, 0);
    next_cycle();
    t_rvalid = 4'b0001;
    t_rdata[31:0] = 32'h1111_0000;
    sample();
    check("t4_r0_rvalid", h_rvalid, 1);
    check("t4_r0_rdata",  h_rdata, 32'h1111_0000);
    check("t4_r2_held",   t_req, 0);
    next_cycle();
    t_rvalid = '0;
    sample();
    check("t4_r2_treq", t_req, 4'b0100);
    check("t4_r2_gnt",  h_gnt, 1);
    next_cycle();
    idle();
    t_rvalid = 4'b0100;
    t_rdata[95:64] = 32'h2222_2222;
    sample();
    check("t4_r2_rvalid", h_rvalid, 1);
    check("t4_r2_rdata",  h_rdata, 32'h2222_2222);
    check("t4_proto",     proto_err, 0);

    // T5: stray response while empty.
    next_cycle();
    idle();
    t_rvalid = 4'b1000;
    t_rdata[127:96] = 32'h3333_3333;
    sample();
    check("t5_rvalid", h_rvalid, 0);
    next_cycle();
    idle();
    sample();
    check("t5_proto", proto_err, 1);
    next_cycle();
    sample();
    check("t5_proto_held", proto_err, 1);

    // T6: reset with three outstanding.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      read_req(32'h1000_0100 + 32'(k * 4), 4'b0010);
    end
    next_cycle();
    idle();
    sample();
    check("t6_cnt_pre", outst_cnt, 3);
    next_cycle();
    read_req(32'h1000_0000, 4'b0010);
    rst = 1'b0;
    sample();
    check("t6_cnt",   outst_cnt, 0);
    check("t6_gnt",   h_gnt, 0);
    check("t6_treq",  t_req, 0);
    check("t6_taddr", t_addr, 0);
    check("t6_proto", proto_err, 0);
    next_cycle();
    rst = 1'b1;
    idle();
    next_cycle();
    read_req(32'h3000_0004, 4'b1000);
    sample();
    check("t6_fresh_gnt",  h_gnt, 1);
    check("t6_fresh_treq", t_req, 4'b1000);
    next_cycle();
    idle();
    t_rvalid = 4'b1000;
    t_rdata[127:96] = 32'hCAFE_F00D;
    sample();
    check("t6_fresh_rvalid", h_rvalid, 1);
    check("t6_fresh_rdata",  h_rdata, 32'hCAFE_F00D);
    next_cycle();
    idle();
    sample();
    check("t6_fresh_cnt",   outst_cnt, 0);
    check("t6_fresh_proto", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
